serial_slice_subtractor: RTL and testbench

// - Multi-cycle, parametrised unsigned/signed subtractor: diff = a - b - bin (mod 2^WIDTH).
// - Processes SLICE bits per clock through a chain of full-subtractor cells.
// - The borrow is registered between slices; a result is ready after WIDTH/SLICE cycles.
// - Sits in the arithmetic datapath where wide subtracts must trade latency for area.
// - Valid/ready handshake on the input and output sides.

---
 rtl/serial_sub_pkg.sv | 26 ++
 rtl/fs_slice.sv | 28 ++
 rtl/serial_slice_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_slice_subtractor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial slice subtractor.
//   sub_state_t : controller state encoding (IDLE, RUN, DONE)
//   clog2       : counter width helper, never returns less than 1
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Width needed to count 0..value-1. A single-slice configuration
    // still needs a 1-bit counter so the register is never zero-width.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fs_slice.sv
// Combinational SLICE-bit ripple of full-subtractor cells.
//   a, b  : slice operands (minuend, subtrahend)
//   bin   : borrow into the least significant cell
//   d     : slice difference
//   bout  : borrow out of the most significant cell
module fs_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    logic br;

    always_comb begin
        d  = '0;
        br = bin;
        for (int i = 0; i < SLICE; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_slice_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), SLICE bits per clock.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result handshake; out_valid is high only in DONE
//   diff, bout, ovf, zero: result, unsigned borrow-out, signed overflow, diff==0
//   state                : current controller state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds in_valid and the operands until in_ready; the result
// and out_valid are held unchanged until out_ready is seen in DONE.
module serial_slice_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output sub_state_t       state
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = clog2(NSL);

    generate
        if ((WIDTH % SLICE) != 0 || SLICE < 1 || SLICE > WIDTH) begin : g_bad_params
            $fatal(1, "serial_slice_subtractor: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    sub_state_t       next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_next;
    logic             br_q;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic [SLICE-1:0] slice_d;
    logic             slice_bout;
    logic             accept;
    logic             last;

    fs_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sr[SLICE-1:0]),
        .b    (b_sr[SLICE-1:0]),
        .bin  (br_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Each new slice enters at the top; after NSL cycles the first slice
    // computed has been pushed down to bit 0.
    generate
        if (NSL == 1) begin : g_single
            assign d_next = slice_d;
        end else begin : g_multi
            assign d_next = {slice_d, d_sr[WIDTH-1:SLICE]};
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(NSL - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath. The visible result registers are written only on the last
    // RUN cycle, so they keep the previous result through IDLE and RUN while
    // the internal shift register fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            br_q  <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            br_q  <= bin;
            cnt   <= '0;
            // Operand sign bits are kept aside: the shift registers lose them.
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sr <= a_sr >> SLICE;
            b_sr <= b_sr >> SLICE;
            d_sr <= d_next;
            br_q <= slice_bout;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff <= d_next;
                bout <= slice_bout;
                zero <= (d_next == '0);
                ovf  <= (a_msb ^ b_msb) & (d_next[WIDTH-1] ^ a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_slice_subtractor.sv
module tb_serial_slice_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic bin = 1'b0;

  logic in_ready, out_valid, bout, ovf, zero;
  logic [W-1:0] diff;
  sub_state_t st;

  logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1, bo1, ovf1, z1;
  logic [W-1:0] d1;
  sub_state_t st1;

  logic iv16 = 1'b0, or16 = 1'b0, ir16, ov16, bo16, ovf16, z16;
  logic [W-1:0] d16;
  sub_state_t st16;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  serial_slice_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero), .state(st)
  );

  serial_slice_subtractor #(.WIDTH(16), .SLICE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .bin(bin), .out_valid(ov1), .out_ready(or1),
    .diff(d1), .bout(bo1), .ovf(ovf1), .zero(z1), .state(st1)
  );

  serial_slice_subtractor #(.WIDTH(16), .SLICE(16)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a), .b(b), .bin(bin), .out_valid(ov16), .out_ready(or16),
    .diff(d16), .bout(bo16), .ovf(ovf16), .zero(z16), .state(st16)
  );

  // reference model: plain wide and signed integer arithmetic
  // result packing: {ovf, zero, bout, diff}
  function automatic logic [W+2:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rbin);
    int ua, ub, ud, sa, sb, sd;
    logic [W-1:0] d;
    logic bo, ov, zr;
    ua = int'(ra);
    ub = int'(rb);
    ud = ua - ub - int'(rbin);
    d  = W'(ud & 32'h0000FFFF);
    bo = (ua < ub + int'(rbin));
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    sd = sa - sb - int'(rbin);
    ov = (sd < -32768) || (sd > 32767);
    zr = (d == '0);
    return {ov, zr, bo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one operation on the main instance, check latency and result,
  // then leave it in DONE (out_ready still low)
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                                input string tag);
    int lat;
    logic [W+2:0] exp;
    exp = ref_model(ta, tb_, tbin);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    check({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
    check({tag, "_bout"}, 32'(bout), 32'(exp[W]));
    check({tag, "_zero"}, 32'(zero), 32'(exp[W+1]));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp[W+2]));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic rbin;
    int lat;

    // reset state
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({bout, ovf, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed cases
    start_and_wait(16'h1234, 16'h0234, 1'b0, "basic");
    check("basic_abs_diff", 32'(diff), 32'h1000);
    release_result("basic");
    start_and_wait(16'h0000, 16'h0001, 1'b0, "wrap");
    check("wrap_abs", 32'({diff, bout, ovf}), {14'd0, 16'hFFFF, 1'b1, 1'b0});
    release_result("wrap");
    start_and_wait(16'h0005, 16'h0004, 1'b1, "bin_zero");
    check("bin_zero_abs", 32'({diff, zero, bout}), {14'd0, 16'h0000, 1'b1, 1'b0});
    release_result("bin_zero");
    start_and_wait(16'h8000, 16'h0001, 1'b0, "sovf");
    check("sovf_abs", 32'({diff, ovf, bout}), {14'd0, 16'h7FFF, 1'b1, 1'b0});
    release_result("sovf");

    // backpressure: result held for 6 cycles, new in_valid ignored
    start_and_wait(16'hBEEF, 16'h1111, 1'b1, "bp");
    held = diff;
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff_stable", 32'(diff), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    tick();
    check("idle_diff_hold", 32'(diff), 32'(held));

    // results stay put during RUN, then reset mid-RUN
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("run_diff_hold", 32'(diff), 32'(held));
    rst_n = 1'b0;
    #1;
    check("midrun_diff", 32'(diff), 32'd0);
    check("midrun_flags", 32'({bout, ovf, zero}), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ra;
      start_and_wait(ra, rb, rbin, "rand");
      release_result("rand");
    end

    // SLICE=1 build reproduces the basic case
    a = 16'h1234; b = 16'h0234; bin = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin
      tick();
      lat++;
    end
    check("s1_latency", 32'(lat), 32'd16);
    check("s1_diff", 32'(d1), 32'h1000);
    check("s1_flags", 32'({bo1, ovf1, z1}), 32'd0);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    check("s1_in_ready_after", 32'(ir1), 32'd1);

    // SLICE=16 build reproduces the basic case
    iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin
      tick();
      lat++;
    end
    check("s16_latency", 32'(lat), 32'd1);
    check("s16_diff", 32'(d16), 32'h1000);
    check("s16_flags", 32'({bo16, ovf16, z16}), 32'd0);
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    check("s16_in_ready_after", 32'(ir16), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
